// File: rtl/b01_tx_pkg.sv
// b01_tx_pkg
// Shared definitions for the b01 serial operand transmitter:
//   - tx_state_t  : transmit FSM states
//   - DEF_WIDTH   : default operand/result width
//   - DEF_RESP_LAT: default LINE-to-OUTP_REG response latency
//   - cnt_width() : width of the per-transaction cycle counters
package b01_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_RESP_LAT = 1;

  // Counters run up to WIDTH+RESP_LAT+1 inside one transaction, so this
  // width guarantees they never wrap.
  function automatic int cnt_width(input int width, input int resp_lat);
    return $clog2(width + resp_lat + 2);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH, DEF_RESP_LAT);

endpackage

// File: rtl/serial_capture.sv
// serial_capture
// Collects the serial result stream returned by b01 into a parallel word.
// A start pulse (the accept edge) clears the result and arms a window
// counter; samples are taken in cycles 1+RESP_LAT .. WIDTH+RESP_LAT after
// the accept edge, each one entering at the MSB so the first sample ends up
// in bit 0.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   start          : one-cycle pulse at the accept edge
//   outp_bit       : serial result bit (OUTP_REG)
//   ovf_bit        : overflow indication (OVERFLW_REG)
//   data           : captured result word
//   ovf            : sticky OR of ovf_bit over the window
module serial_capture
  import b01_tx_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int RESP_LAT = DEF_RESP_LAT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             outp_bit,
  input  logic             ovf_bit,
  output logic [WIDTH-1:0] data,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH, RESP_LAT);
  localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(1 + RESP_LAT);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIDTH + RESP_LAT);

  logic [CNT_W-1:0] win_cnt;   // cycle index since the accept edge
  logic             active;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      win_cnt <= '0;
      active  <= 1'b0;
      data    <= '0;
      ovf     <= 1'b0;
    end else if (start) begin
      // Value seen during cycle 1 after the accept edge.
      win_cnt <= CNT_W'(1);
      active  <= 1'b1;
      data    <= '0;
      ovf     <= 1'b0;
    end else if (active) begin
      if (win_cnt >= WIN_FIRST) begin
        data <= {outp_bit, data[WIDTH-1:1]};
        if (ovf_bit) begin
          ovf <= 1'b1;
        end
      end
      if (win_cnt == WIN_LAST) begin
        active  <= 1'b0;
        win_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/b01_serial_operand_tx.sv
// b01_serial_operand_tx
// Transmit-side companion for the b01 serial compare/add FSM. Accepts an
// operand pair over valid/ready, shifts both operands LSB-first onto
// LINE1/LINE2, and captures the returned OUTP_REG/OVERFLW_REG stream.
// Ports:
//   clock, reset_n       : clock and synchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   in_a, in_b           : operands for LINE1 / LINE2
//   LINE1, LINE2         : registered serial operand bits to b01
//   OUTP_REG, OVERFLW_REG: serial result and overflow from b01
//   res_valid            : one-cycle pulse when res_data/res_ovf are final
//   res_data, res_ovf    : captured result word and sticky overflow
//   busy                 : high whenever the FSM is not IDLE
module b01_serial_operand_tx
  import b01_tx_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int RESP_LAT = DEF_RESP_LAT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             LINE1,
  output logic             LINE2,
  input  logic             OUTP_REG,
  input  logic             OVERFLW_REG,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH, RESP_LAT);
  localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIDTH + RESP_LAT);

  tx_state_t        state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [CNT_W-1:0] bit_cnt;   // cycle index since the accept edge
  logic             start;

  assign start    = in_valid && (state == IDLE);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_a   <= '0;
      shift_b   <= '0;
      bit_cnt   <= '0;
      LINE1     <= 1'b0;
      LINE2     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          LINE1     <= 1'b0;
          LINE2     <= 1'b0;
          if (in_valid) begin
            // Bit 0 goes out straight away so it is on the line in cycle 1.
            LINE1   <= in_a[0];
            LINE2   <= in_b[0];
            shift_a <= {1'b0, in_a[WIDTH-1:1]};
            shift_b <= {1'b0, in_b[WIDTH-1:1]};
            bit_cnt <= CNT_W'(1);
            state   <= SEND;
          end
        end
        SEND: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == SEND_LAST) begin
            LINE1 <= 1'b0;
            LINE2 <= 1'b0;
            if (RESP_LAT == 0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            LINE1   <= shift_a[0];
            LINE2   <= shift_b[0];
            shift_a <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b <= {1'b0, shift_b[WIDTH-1:1]};
          end
        end
        DRAIN: begin
          // The capture window closes at the edge ending cycle WIDTH+RESP_LAT.
          if (bit_cnt == DRAIN_LAST) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          res_valid <= 1'b0;
          bit_cnt   <= '0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  serial_capture #(
    .WIDTH   (WIDTH),
    .RESP_LAT(RESP_LAT)
  ) u_capture (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .outp_bit(OUTP_REG),
    .ovf_bit (OVERFLW_REG),
    .data    (res_data),
    .ovf     (res_ovf)
  );

endmodule

// File: tb/tb_b01_serial_operand_tx.sv
// tb_b01_serial_operand_tx
// Directed bench for b01_serial_operand_tx. Two instances: dut1 (RESP_LAT=1)
// with a loopback of selectable delay, dut3 (RESP_LAT=3) with a fixed
// 3-cycle loopback. Expected results are queued when an operand pair is
// accepted and compared when res_valid pulses, including the cycle it
// arrives in.
module tb_b01_serial_operand_tx;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] opa = 8'h00;
  logic [7:0] opb = 8'h00;

  logic v1 = 1'b0, v3 = 1'b0;
  logic ovf1 = 1'b0, ovf3 = 1'b0;
  logic rdy1, rdy3, l1_1, l2_1, l1_3, l2_3;
  logic rv1, rv3, ro1, ro3, busy1, busy3;
  logic [7:0] rd1, rd3;
  logic outp1, outp3;
  logic [7:0] hist1 = 8'h00, hist3 = 8'h00;
  int lb1 = 1;

  int cycle = 0;
  int tests = 0;
  int fails = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Loopback: OUTP_REG echoes LINE1 after a configurable number of cycles.
  always @(posedge clk) begin
    hist1 <= {hist1[6:0], l1_1};
    hist3 <= {hist3[6:0], l1_3};
  end
  assign outp1 = hist1[lb1-1];
  assign outp3 = hist3[2];

  b01_serial_operand_tx #(.WIDTH(8), .RESP_LAT(1)) dut1 (
    .clock(clk), .reset_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_a(opa), .in_b(opb), .LINE1(l1_1), .LINE2(l2_1),
    .OUTP_REG(outp1), .OVERFLW_REG(ovf1), .res_valid(rv1),
    .res_data(rd1), .res_ovf(ro1), .busy(busy1)
  );

  b01_serial_operand_tx #(.WIDTH(8), .RESP_LAT(3)) dut3 (
    .clock(clk), .reset_n(rst_n), .in_valid(v3), .in_ready(rdy3),
    .in_a(opa), .in_b(opb), .LINE1(l1_3), .LINE2(l2_3),
    .OUTP_REG(outp3), .OVERFLW_REG(ovf3), .res_valid(rv3),
    .res_data(rd3), .res_ovf(ro3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitors.
  always @(negedge clk) begin
    if (rv1 === 1'b1 && q1.size() == 0) begin
      check("r1_spurious_valid", 32'(rv1), 32'd0);
    end else if (rv1 === 1'b1) begin
      exp_t e;
      e = q1.pop_front();
      $display("[TB] dut1 result data=0x%02h ovf=%0d cycle=%0d", rd1, ro1, cycle);
      check("r1_data", 32'(rd1), 32'(e.data));
      check("r1_ovf", 32'(ro1), 32'(e.ovf));
      check("r1_latency", 32'(cycle), 32'(e.due));
    end
    if (rv3 === 1'b1 && q3.size() == 0) begin
      check("r3_spurious_valid", 32'(rv3), 32'd0);
    end else if (rv3 === 1'b1) begin
      exp_t e;
      e = q3.pop_front();
      $display("[TB] dut3 result data=0x%02h ovf=%0d cycle=%0d", rd3, ro3, cycle);
      check("r3_data", 32'(rd3), 32'(e.data));
      check("r3_ovf", 32'(ro3), 32'(e.ovf));
      check("r3_latency", 32'(cycle), 32'(e.due));
    end
  end

  // One dut1 transaction. The caller is in cycle 0 (idle). ovf_at selects the
  // cycle OVERFLW_REG is pulsed (0 = never); lb is the loopback delay.
  task automatic run_tx1(input logic [7:0] ta, input logic [7:0] tbv,
                         input int ovf_at, input int lb);
    logic [7:0] ed;
    logic       eo;
    lb1 = lb;
    // Extra loopback delay beyond RESP_LAT slides the captured bits upward.
    ed = 8'(ta << (lb - 1));
    eo = (ovf_at >= 2 && ovf_at <= 9);
    opa = ta;
    opb = tbv;
    v1 = 1'b1;
    q1.push_back('{ed, eo, cycle + 10});
    for (int k = 1; k <= 12; k++) begin
      tick();
      v1 = 1'b0;
      ovf1 = (k == ovf_at);
      if (k <= 8) begin
        check("line1_bit", 32'(l1_1), 32'(ta[k-1]));
        check("line2_bit", 32'(l2_1), 32'(tbv[k-1]));
      end else if (k == 9) begin
        check("line_idle_after_send", 32'({l1_1, l2_1}), 32'd0);
      end
      check("in_ready_seq", 32'(rdy1), 32'(k >= 11));
    end
    check("hold_data", 32'(rd1), 32'(ed));
    check("hold_ovf", 32'(ro1), 32'(eo));
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(rdy1), 32'd1);
    check("rst_lines", 32'({l1_1, l2_1, l1_3, l2_3}), 32'd0);
    check("rst_res_valid", 32'({rv1, rv3}), 32'd0);
    check("rst_res_data", 32'(rd1), 32'd0);
    check("rst_res_ovf", 32'({ro1, ro3}), 32'd0);
    check("rst_busy", 32'({busy1, busy3}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic loopback transfers and overflow window boundaries.
    run_tx1(8'hA5, 8'h3C, 0, 1);
    run_tx1(8'hA5, 8'h3C, 5, 1);
    run_tx1(8'hA5, 8'h3C, 11, 1);
    run_tx1(8'h5A, 8'hC3, 1, 1);
    run_tx1(8'h5A, 8'hC3, 2, 1);
    run_tx1(8'h00, 8'hFF, 9, 1);
    run_tx1(8'hFF, 8'h00, 10, 1);

    // in_valid held high: accepts every 11 cycles, operands frozen at accept.
    opa = 8'hFF;
    opb = 8'h00;
    lb1 = 1;
    v1 = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      check("cont_in_ready", 32'(rdy1), 32'((k % 11) == 0));
      if (k >= 1 && k <= 8) check("cont_line1", 32'(l1_1), 32'd1);
      if (k == 0) q1.push_back('{8'hFF, 1'b0, cycle + 10});
      if (k == 11) q1.push_back('{8'h0F, 1'b0, cycle + 10});
      if (k == 4) opa = 8'h0F;
      if (k == 22) v1 = 1'b0;
      tick();
    end
    tick();

    // Reset in cycle 4 of a transfer aborts it.
    opa = 8'hC3;
    opb = 8'h5A;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_before", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_lines", 32'({l1_1, l2_1}), 32'd0);
    check("abort_in_ready", 32'(rdy1), 32'd1);
    check("abort_res_data", 32'(rd1), 32'd0);
    repeat (14) tick();

    // Reset coinciding with an accept edge wins.
    opa = 8'hFF;
    opb = 8'hFF;
    v1 = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    v1 = 1'b0;
    check("rst_accept_busy", 32'(busy1), 32'd0);
    check("rst_accept_line", 32'({l1_1, l2_1}), 32'd0);
    tick();
    check("rst_accept_idle", 32'(rdy1), 32'd1);
    repeat (3) tick();

    // RESP_LAT=3 instance with a matching 3-cycle loopback.
    opa = 8'h01;
    opb = 8'h00;
    v3 = 1'b1;
    q3.push_back('{8'h01, 1'b0, cycle + 12});
    tick();
    v3 = 1'b0;
    repeat (13) tick();
    opa = 8'hB6;
    opb = 8'h11;
    v3 = 1'b1;
    q3.push_back('{8'hB6, 1'b0, cycle + 12});
    tick();
    v3 = 1'b0;
    repeat (13) tick();

    // RESP_LAT=1 instance fed by a 3-cycle loopback: bits land two places up.
    run_tx1(8'h01, 8'h00, 0, 3);
    run_tx1(8'hA5, 8'h3C, 0, 3);
    lb1 = 1;

    repeat (3) tick();
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
